// File: rtl/e1_tick_monitor_pkg.sv
// Shared constants for the E1 tick monitor: register map, CSR bit positions,
// counter indices and control state encoding.
package e1_tick_monitor_pkg;

  localparam logic [3:0] REG_CSR        = 4'h0;
  localparam logic [3:0] REG_SNAP_TICKS = 4'h1;
  localparam logic [3:0] REG_SNAP_CYC   = 4'h2;
  localparam logic [3:0] REG_LIVE       = 4'h3;

  localparam int CSR_EN      = 0;
  localparam int CSR_VALID   = 1;
  localparam int CSR_OVF     = 2;
  localparam int CSR_TMO     = 3;
  localparam int CSR_SEQ_LSB = 16;

  localparam int CNT_RX  = 0;
  localparam int CNT_TX  = 1;
  localparam int CNT_CYC = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. load1 restarts at 1 (a tick landing on the restart
// edge), clr restarts at 0; at all-ones the count holds and sat is high.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  assign sat = &q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load1) begin
      q <= W'(1);
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/e1_tick_monitor.sv
// Counts E1 RX/TX bit ticks and clk cycles between USB SOFs, snapshots them
// once per frame and exposes the results on a small Wishbone register file.
module e1_tick_monitor
  import e1_tick_monitor_pkg::*;
#(
  parameter int unsigned SOF_TIMEOUT = 61440,
  parameter int unsigned CW          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_e1_rx,
  input  logic        tick_e1_tx,
  input  logic        tick_usb_sof,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic [31:0] wb_rdata,
  output logic        wb_ack
);

  localparam logic [31:0] TMO_LAST = 32'(SOF_TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic            en_reg, valid_reg, ovf_reg, tmo_reg;
  logic [15:0]     seq_reg;
  logic [CW-1:0]   snap_rx_reg, snap_tx_reg, snap_cyc_reg;
  logic            ack_reg;
  logic [31:0]     rdata_reg;

  logic [2:0]      cnt_inc, cnt_sat;
  logic [CW-1:0]   cnt_q [3];
  logic            restart, zero_cnt, take_snap, tmo_evt, clr_valid;
  logic            cyc_at_limit, bus_acc, csr_wr;
  logic [31:0]     csr_word, rd_mux;
  logic            unused_wdata;

  assign cnt_inc      = {1'b1, tick_e1_tx, tick_e1_rx};
  // Compared at 32 bits so a timeout beyond the counter range never fires.
  assign cyc_at_limit = (32'(cnt_q[CNT_CYC]) == TMO_LAST);

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    sat_counter #(.W(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (zero_cnt | restart),
      .load1 (restart & cnt_inc[gi]),
      .inc   (cnt_inc[gi]),
      .q     (cnt_q[gi]),
      .sat   (cnt_sat[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    zero_cnt   = 1'b0;
    take_snap  = 1'b0;
    tmo_evt    = 1'b0;
    if (!en_reg) begin
      state_next = IDLE;
      zero_cnt   = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = ARM;
          zero_cnt   = 1'b1;
        end
        ARM: begin
          if (tick_usb_sof) begin
            state_next = RUN;
            restart    = 1'b1;
          end else if (cyc_at_limit) begin
            tmo_evt  = 1'b1;
            zero_cnt = 1'b1;
          end
        end
        RUN: begin
          if (tick_usb_sof) begin
            restart   = 1'b1;
            take_snap = 1'b1;
          end else if (cyc_at_limit) begin
            state_next = ARM;
            tmo_evt    = 1'b1;
            zero_cnt   = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign clr_valid = tmo_evt | ~en_reg;

  // A bus access is serviced on the edge that raises ack.
  assign bus_acc = wb_cyc & ~ack_reg;
  assign csr_wr  = bus_acc & wb_we & (wb_addr == REG_CSR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg       <= 1'b0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      tmo_reg      <= 1'b0;
      seq_reg      <= '0;
      snap_rx_reg  <= '0;
      snap_tx_reg  <= '0;
      snap_cyc_reg <= '0;
    end else begin
      if (csr_wr) en_reg <= wb_wdata[CSR_EN];

      if (take_snap)      valid_reg <= 1'b1;
      else if (clr_valid) valid_reg <= 1'b0;

      // Hardware set takes priority over a same-cycle write-1-to-clear.
      if (|cnt_sat)                         ovf_reg <= 1'b1;
      else if (csr_wr && wb_wdata[CSR_OVF]) ovf_reg <= 1'b0;

      if (tmo_evt)                          tmo_reg <= 1'b1;
      else if (csr_wr && wb_wdata[CSR_TMO]) tmo_reg <= 1'b0;

      if (take_snap) begin
        seq_reg      <= seq_reg + 16'd1;
        snap_rx_reg  <= cnt_q[CNT_RX];
        snap_tx_reg  <= cnt_q[CNT_TX];
        snap_cyc_reg <= cnt_q[CNT_CYC];
      end
    end
  end

  always_comb begin
    csr_word                            = '0;
    csr_word[CSR_EN]                    = en_reg;
    csr_word[CSR_VALID]                 = valid_reg;
    csr_word[CSR_OVF]                   = ovf_reg;
    csr_word[CSR_TMO]                   = tmo_reg;
    csr_word[CSR_SEQ_LSB +: 16]         = seq_reg;
  end

  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      REG_CSR:        rd_mux = csr_word;
      REG_SNAP_TICKS: rd_mux = {16'(snap_tx_reg), 16'(snap_rx_reg)};
      REG_SNAP_CYC:   rd_mux = {16'd0, 16'(snap_cyc_reg)};
      REG_LIVE:       rd_mux = {16'(cnt_q[CNT_TX]), 16'(cnt_q[CNT_RX])};
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg   <= wb_cyc & ~ack_reg;
      rdata_reg <= (bus_acc && !wb_we) ? rd_mux : 32'd0;
    end
  end

  assign wb_ack       = ack_reg;
  assign wb_rdata     = rdata_reg;
  assign unused_wdata = ^{wb_wdata[31:4], wb_wdata[CSR_VALID]};

endmodule

// File: tb/tb_e1_tick_monitor.sv
// Directed bench for e1_tick_monitor: a short-timeout instance for the frame,
// timeout and bus sequences, plus a long-timeout instance for saturation.
module tb_e1_tick_monitor;
  import e1_tick_monitor_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tick_e1_rx, tick_e1_tx, tick_usb_sof;
  logic [3:0]  wb_addr;
  logic [31:0] wb_wdata, wb_rdata;
  logic        wb_we, wb_cyc, wb_ack;

  logic        o_rst_n, o_rx, o_we, o_cyc, o_ack;
  logic        o_tie0 = 1'b0;
  logic [3:0]  o_addr;
  logic [31:0] o_wdata, o_rdata;

  e1_tick_monitor #(.SOF_TIMEOUT(4096), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick_e1_rx(tick_e1_rx), .tick_e1_tx(tick_e1_tx),
    .tick_usb_sof(tick_usb_sof), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_rdata(wb_rdata), .wb_ack(wb_ack)
  );

  e1_tick_monitor #(.SOF_TIMEOUT(32'h1FFFF), .CW(16)) dut_ovf (
    .clk(clk), .rst_n(o_rst_n), .tick_e1_rx(o_rx), .tick_e1_tx(o_tie0),
    .tick_usb_sof(o_tie0), .wb_addr(o_addr), .wb_wdata(o_wdata),
    .wb_we(o_we), .wb_cyc(o_cyc), .wb_rdata(o_rdata), .wb_ack(o_ack)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit ovf_done = 1'b0;

  int gen_cnt = 0, rx_per = 0, tx_per = 0, sof_per = 0, sof_left = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Drive tick/SOF inputs for the coming posedge, then advance to the next negedge.
  task automatic cyc1();
    tick_e1_rx   = (rx_per != 0) && (gen_cnt % rx_per == 0);
    tick_e1_tx   = (tx_per != 0) && (gen_cnt % tx_per == 0);
    tick_usb_sof = 1'b0;
    if (sof_left > 0 && sof_per != 0 && gen_cnt % sof_per == 0) begin
      tick_usb_sof = 1'b1;
      sof_left--;
    end
    gen_cnt++;
    @(negedge clk);
  endtask

  task automatic bus(input logic [3:0] a, input logic we, input logic [31:0] wd,
                     output logic [31:0] rd);
    wb_addr = a; wb_we = we; wb_wdata = wd; wb_cyc = 1'b1;
    cyc1();
    check_eq($sformatf("ack_%s_%0h", we ? "wr" : "rd", a), 32'(wb_ack), 32'd1);
    rd = wb_rdata;
    wb_cyc = 1'b0; wb_we = 1'b0;
    cyc1();
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(a, 1'b0, 32'd0, v);
    check_eq(tag, v, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] v;
    bus(a, 1'b1, d, v);
  endtask

  task automatic bus_o(input logic [3:0] a, input logic we, input logic [31:0] wd,
                       output logic [31:0] rd);
    o_addr = a; o_we = we; o_wdata = wd; o_cyc = 1'b1;
    @(negedge clk);
    check_eq("ovf_ack", 32'(o_ack), 32'd1);
    rd = o_rdata;
    o_cyc = 1'b0; o_we = 1'b0;
    @(negedge clk);
  endtask

  // Saturation instance: RX ticks every cycle, long timeout never reached.
  initial begin
    logic [31:0] v;
    o_rst_n = 1'b0; o_rx = 1'b0; o_cyc = 1'b0; o_we = 1'b0; o_addr = '0; o_wdata = '0;
    repeat (3) @(negedge clk);
    o_rst_n = 1'b1;
    @(negedge clk);
    bus_o(REG_CSR, 1'b1, 32'h1, v);
    o_rx = 1'b1;
    repeat (70000) @(negedge clk);
    bus_o(REG_LIVE, 1'b0, 32'd0, v);
    check_eq("ovf_live_sat", v, 32'h0000_FFFF);
    bus_o(REG_CSR, 1'b0, 32'd0, v);
    check_eq("ovf_csr", v, 32'h0000_0005);
    bus_o(REG_CSR, 1'b1, 32'h5, v);
    bus_o(REG_CSR, 1'b0, 32'd0, v);
    check_eq("ovf_w1c_hw_wins", v, 32'h0000_0005);
    ovf_done = 1'b1;
  end

  logic [3:0]  b2b_addr [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7};
  logic [31:0] b2b_exp  [5] = '{32'h0003_0000, 32'd0, 32'd100, 32'd0, 32'd0};

  initial begin
    rst_n = 1'b0; tick_e1_rx = 1'b0; tick_e1_tx = 1'b0; tick_usb_sof = 1'b0;
    wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_ack", 32'(wb_ack), 32'd0);
    check_eq("reset_rdata", wb_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("reset_csr", REG_CSR, 32'd0);
    rd_chk("reset_snap_ticks", REG_SNAP_TICKS, 32'd0);
    rd_chk("reset_snap_cyc", REG_SNAP_CYC, 32'd0);

    // IDLE keeps the counters at zero even with ticks present.
    rx_per = 1;
    repeat (20) cyc1();
    rd_chk("idle_live", REG_LIVE, 32'd0);
    rx_per = 0;

    // Three SOFs 1920 cycles apart, RX every 15, TX every 16.
    wr(REG_CSR, 32'h1);
    gen_cnt = 0; rx_per = 15; tx_per = 16; sof_per = 1920; sof_left = 3;
    repeat (100) cyc1();
    rd_chk("run_csr_first", REG_CSR, 32'h0000_0001);
    while (gen_cnt < 3841) cyc1();
    rx_per = 0; tx_per = 0;
    rd_chk("snap_ticks", REG_SNAP_TICKS, 32'h0078_0080);
    rd_chk("snap_cyc", REG_SNAP_CYC, 32'd1920);
    rd_chk("csr_after_3sof", REG_CSR, 32'h0002_0003);
    rd_chk("live_after_coincident", REG_LIVE, 32'h0001_0001);

    // No SOF: timeout back to ARM.
    repeat (4200) cyc1();
    rd_chk("tmo_csr", REG_CSR, 32'h0002_0009);
    rd_chk("tmo_live", REG_LIVE, 32'd0);
    wr(REG_CSR, 32'h9);
    rd_chk("tmo_cleared", REG_CSR, 32'h0002_0001);

    // From ARM the first SOF only starts the interval; the second snapshots.
    gen_cnt = 0; sof_per = 100; sof_left = 2;
    while (gen_cnt < 101) cyc1();
    rd_chk("arm_snap_cyc", REG_SNAP_CYC, 32'd100);
    rd_chk("arm_csr", REG_CSR, 32'h0003_0003);
    rd_chk("arm_snap_ticks", REG_SNAP_TICKS, 32'd0);

    wr(REG_CSR, 32'h0);
    rd_chk("idle_csr", REG_CSR, 32'h0003_0000);
    wr(4'h7, 32'hFFFF_FFFF);
    rd_chk("unmapped_wr", REG_CSR, 32'h0003_0000);

    // Back-to-back reads with wb_cyc held high.
    wb_cyc = 1'b1; wb_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_addr = b2b_addr[i];
      cyc1();
      check_eq($sformatf("b2b_ack[%0d]", i), 32'(wb_ack), 32'd1);
      check_eq($sformatf("b2b_data[%0d]", i), wb_rdata, b2b_exp[i]);
      cyc1();
      check_eq($sformatf("b2b_gap_ack[%0d]", i), 32'(wb_ack), 32'd0);
      check_eq($sformatf("b2b_gap_data[%0d]", i), wb_rdata, 32'd0);
    end
    wb_cyc = 1'b0;
    cyc1();

    // Asynchronous reset between clock edges while ack is high.
    wr(REG_CSR, 32'h1);
    gen_cnt = 0; rx_per = 3;
    repeat (50) cyc1();
    wb_addr = REG_CSR; wb_we = 1'b0; wb_cyc = 1'b1;
    cyc1();
    check_eq("rst_pre_ack", 32'(wb_ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_ack", 32'(wb_ack), 32'd0);
    check_eq("rst_async_rdata", wb_rdata, 32'd0);
    wb_cyc = 1'b0; rx_per = 0;
    @(negedge clk);
    cyc1();
    rst_n = 1'b1;
    cyc1();
    rd_chk("post_rst_csr", REG_CSR, 32'd0);
    rd_chk("post_rst_snap_cyc", REG_SNAP_CYC, 32'd0);
    rd_chk("post_rst_live", REG_LIVE, 32'd0);

    for (int i = 0; i < 80000 && !ovf_done; i++) @(negedge clk);
    if (!ovf_done) check_eq("ovf_seq_done", 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
